// File: rtl/sc_randchk_pkg.sv
// Shared types and constants for the serial random-stream checker.
package sc_randchk_pkg;

  // Checker FSM: gather seed bits, then predict every following bit.
  typedef enum logic {
    SEED   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Feedback taps 6,5,3,0 of the 8-bit random register.
  localparam logic [7:0] TAPS = 8'b0110_1001;

  // Number of received bits needed to fill the shadow register.
  localparam int SEED_LEN = 8;

  // Seed used by the bench generator model.
  localparam logic [7:0] BENCH_SEED = 8'h99;

endpackage

// File: rtl/sc_randchk_lfsr_if.sv
// Stream/status bundle for sc_randchk_lfsr.
// Optional macro RANDCHK_BITCNT_EN adds the 32-bit locked-bit counter.
//
// Handshake: the producer drives SC_RandCHK_bit_In together with
// SC_RandCHK_valid_In; every cycle with valid high consumes exactly one bit
// and there is no back-pressure (the checker is always ready). Clear
// outranks valid, and a bit presented together with clear is discarded.
interface sc_randchk_lfsr_if
  import sc_randchk_pkg::*;
#(
  parameter int ERRCNT_WIDTH = 16
);
  logic                    SC_RandCHK_bit_In;
  logic                    SC_RandCHK_valid_In;
  logic                    SC_RandCHK_clear_In;
  logic                    SC_RandCHK_locked_Out;
  logic                    SC_RandCHK_error_Out;
  logic                    SC_RandCHK_zerolock_Out;
  logic [ERRCNT_WIDTH-1:0] SC_RandCHK_errcnt_OutBUS;
  logic [7:0]              SC_RandCHK_shadow_OutBUS;
  state_t                  SC_RandCHK_state_Dbg;
`ifdef RANDCHK_BITCNT_EN
  logic [31:0]             SC_RandCHK_bitcnt_OutBUS;
`endif

  modport master (
    output SC_RandCHK_bit_In, SC_RandCHK_valid_In, SC_RandCHK_clear_In,
    input  SC_RandCHK_locked_Out, SC_RandCHK_error_Out, SC_RandCHK_zerolock_Out,
    input  SC_RandCHK_errcnt_OutBUS, SC_RandCHK_shadow_OutBUS, SC_RandCHK_state_Dbg
`ifdef RANDCHK_BITCNT_EN
    , input SC_RandCHK_bitcnt_OutBUS
`endif
  );

  modport slave (
    input  SC_RandCHK_bit_In, SC_RandCHK_valid_In, SC_RandCHK_clear_In,
    output SC_RandCHK_locked_Out, SC_RandCHK_error_Out, SC_RandCHK_zerolock_Out,
    output SC_RandCHK_errcnt_OutBUS, SC_RandCHK_shadow_OutBUS, SC_RandCHK_state_Dbg
`ifdef RANDCHK_BITCNT_EN
    , output SC_RandCHK_bitcnt_OutBUS
`endif
  );

endinterface

// File: rtl/sc_randchk_lfsr_next.sv
// Combinational feedback bit of the 8-bit random register: XOR of the tapped
// bits (6,5,3,0). Bit 7 is masked out by the tap constant.
module sc_randchk_lfsr_next
  import sc_randchk_pkg::*;
(
  input  logic [7:0] i_s,
  output logic       o_fb
);

  logic [7:0] w_masked;

  // Parity over the tapped bits is the next bit the generator will emit.
  always_comb begin
    w_masked = i_s & TAPS;
    o_fb     = ^w_masked;
  end

endmodule

// File: rtl/sc_randchk_lfsr.sv
// Serial checker for the 8-bit random-register bit stream.
// Seeds a shadow register from 8 received bits, then predicts each following
// bit, pulses error on mismatch and counts errors (saturating). Too many
// consecutive misses drop lock and restart seeding.
// Optional macro RANDCHK_BITCNT_EN adds a saturating count of bits checked
// while locked.
module sc_randchk_lfsr
  import sc_randchk_pkg::*;
#(
  parameter int ERRCNT_WIDTH = 16,
  parameter int LOSS_THRESH  = 4
) (
  input  logic              SC_RandCHK_CLOCK_50,
  input  logic              SC_RandCHK_RESET_InHigh,
  sc_randchk_lfsr_if.slave  bus
);

  localparam logic [ERRCNT_WIDTH-1:0] ERR_ONE = {{(ERRCNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERRCNT_WIDTH-1:0] ERR_MAX = {ERRCNT_WIDTH{1'b1}};

  logic w_bit;
  logic w_valid;
  logic w_clear;
  logic w_fb;

  state_t                  r_state,    w_state_nxt;
  logic [7:0]              r_shadow,   w_shadow_nxt;
  logic [3:0]              r_cnt,      w_cnt_nxt;
  logic [3:0]              r_miss,     w_miss_nxt;
  logic [3:0]              w_miss_inc;
  logic                    r_locked,   w_locked_nxt;
  logic                    r_zerolock, w_zerolock_nxt;
  logic                    r_error,    w_error_nxt;
  logic [ERRCNT_WIDTH-1:0] r_errcnt,   w_errcnt_nxt;
`ifdef RANDCHK_BITCNT_EN
  logic [31:0]             r_bitcnt,   w_bitcnt_nxt;
`endif

  assign w_bit   = bus.SC_RandCHK_bit_In;
  assign w_valid = bus.SC_RandCHK_valid_In;
  assign w_clear = bus.SC_RandCHK_clear_In;

  sc_randchk_lfsr_next u_next (
    .i_s  (r_shadow),
    .o_fb (w_fb)
  );

  assign w_miss_inc = r_miss + 4'd1;

  // Next-state and next-output logic: clear beats valid, idle cycles hold.
  always_comb begin
    w_state_nxt    = r_state;
    w_shadow_nxt   = r_shadow;
    w_cnt_nxt      = r_cnt;
    w_miss_nxt     = r_miss;
    w_locked_nxt   = r_locked;
    w_zerolock_nxt = r_zerolock;
    w_error_nxt    = 1'b0;
    w_errcnt_nxt   = r_errcnt;
`ifdef RANDCHK_BITCNT_EN
    w_bitcnt_nxt   = r_bitcnt;
`endif
    if (w_clear) begin
      w_state_nxt    = SEED;
      w_shadow_nxt   = 8'h00;
      w_cnt_nxt      = 4'd0;
      w_miss_nxt     = 4'd0;
      w_locked_nxt   = 1'b0;
      w_zerolock_nxt = 1'b0;
      w_errcnt_nxt   = '0;
`ifdef RANDCHK_BITCNT_EN
      w_bitcnt_nxt   = 32'd0;
`endif
    end else if (w_valid) begin
      case (r_state)
        SEED: begin
          w_shadow_nxt = {r_shadow[6:0], w_bit};
          if (r_cnt == 4'(SEED_LEN - 1)) begin
            w_cnt_nxt = 4'd0;
            // An all-zero S[6:0] would predict zeros forever: refuse to lock.
            if ({r_shadow[5:0], w_bit} == 7'd0) begin
              w_zerolock_nxt = 1'b1;
            end else begin
              w_zerolock_nxt = 1'b0;
              w_locked_nxt   = 1'b1;
              w_state_nxt    = LOCKED;
            end
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        LOCKED: begin
          // Shift the prediction, not the received bit, so one bad bit
          // does not corrupt later predictions.
          w_shadow_nxt = {r_shadow[6:0], w_fb};
`ifdef RANDCHK_BITCNT_EN
          if (r_bitcnt != 32'hFFFF_FFFF) w_bitcnt_nxt = r_bitcnt + 32'd1;
`endif
          if (w_bit != w_fb) begin
            w_error_nxt = 1'b1;
            if (r_errcnt != ERR_MAX) w_errcnt_nxt = r_errcnt + ERR_ONE;
            if (w_miss_inc == 4'(LOSS_THRESH)) begin
              w_miss_nxt   = 4'd0;
              w_cnt_nxt    = 4'd0;
              w_locked_nxt = 1'b0;
              w_state_nxt  = SEED;
            end else begin
              w_miss_nxt = w_miss_inc;
            end
          end else begin
            w_miss_nxt = 4'd0;
          end
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge SC_RandCHK_CLOCK_50 or posedge SC_RandCHK_RESET_InHigh) begin
    if (SC_RandCHK_RESET_InHigh) begin
      r_state    <= SEED;
      r_shadow   <= 8'h00;
      r_cnt      <= 4'd0;
      r_miss     <= 4'd0;
      r_locked   <= 1'b0;
      r_zerolock <= 1'b0;
      r_error    <= 1'b0;
      r_errcnt   <= '0;
`ifdef RANDCHK_BITCNT_EN
      r_bitcnt   <= 32'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shadow   <= w_shadow_nxt;
      r_cnt      <= w_cnt_nxt;
      r_miss     <= w_miss_nxt;
      r_locked   <= w_locked_nxt;
      r_zerolock <= w_zerolock_nxt;
      r_error    <= w_error_nxt;
      r_errcnt   <= w_errcnt_nxt;
`ifdef RANDCHK_BITCNT_EN
      r_bitcnt   <= w_bitcnt_nxt;
`endif
    end
  end

  assign bus.SC_RandCHK_locked_Out    = r_locked;
  assign bus.SC_RandCHK_error_Out     = r_error;
  assign bus.SC_RandCHK_zerolock_Out  = r_zerolock;
  assign bus.SC_RandCHK_errcnt_OutBUS = r_errcnt;
  assign bus.SC_RandCHK_shadow_OutBUS = r_shadow;
  assign bus.SC_RandCHK_state_Dbg     = r_state;
`ifdef RANDCHK_BITCNT_EN
  assign bus.SC_RandCHK_bitcnt_OutBUS = r_bitcnt;
`endif

endmodule
